// File: rtl/fc_layer_sequencer_pkg.sv
// Shared definitions for the fully-connected layer sequencer: FSM states
// and the lane geometry of the 4-wide MAC datapath.
package fc_pkg;

    localparam int NUM_LANE = 4;
    localparam int LANE_BIT = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// Control, data-mover and result-BRAM signals of the layer sequencer.
// The master modport is the sequencer's view.
interface fc_layer_sequencer_if #(
    parameter int CNT_BIT = 31,
    parameter int GRP_BIT = 10,
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 12
);
    logic               i_run;
    logic [CNT_BIT-1:0] i_num_cnt;
    logic [GRP_BIT-1:0] i_num_grp;
    logic [AWIDTH-1:0]  i_res_base;
    logic               o_idle;
    logic               o_busy;
    logic               o_done;

    logic               o_dm_run;
    logic [CNT_BIT-1:0] o_dm_num_cnt;
    logic [AWIDTH-1:0]  o_wgt_base;
    logic               i_dm_idle;
    logic               i_dm_done;
    logic [DWIDTH-1:0]  i_result_0;
    logic [DWIDTH-1:0]  i_result_1;
    logic [DWIDTH-1:0]  i_result_2;
    logic [DWIDTH-1:0]  i_result_3;

    logic [AWIDTH-1:0]  o_wr_addr;
    logic               o_wr_ce;
    logic               o_wr_we;
    logic [DWIDTH-1:0]  o_wr_data;

    modport master (
        input  i_run, i_num_cnt, i_num_grp, i_res_base,
        output o_idle, o_busy, o_done,
        output o_dm_run, o_dm_num_cnt, o_wgt_base,
        input  i_dm_idle, i_dm_done, i_result_0, i_result_1, i_result_2, i_result_3,
        output o_wr_addr, o_wr_ce, o_wr_we, o_wr_data
    );

    modport slave (
        output i_run, i_num_cnt, i_num_grp, i_res_base,
        input  o_idle, o_busy, o_done,
        input  o_dm_run, o_dm_num_cnt, o_wgt_base,
        output i_dm_idle, i_dm_done, i_result_0, i_result_1, i_result_2, i_result_3,
        input  o_wr_addr, o_wr_ce, o_wr_we, o_wr_data
    );
endinterface

// File: rtl/fc_layer_sequencer_result_buffer.sv
// Four-lane capture register for the data mover ReLU results, read back
// one lane at a time during the write burst.
module fc_result_buffer
    import fc_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [DWIDTH-1:0]   din [NUM_LANE],
    input  logic [LANE_BIT-1:0] sel,
    output logic [DWIDTH-1:0]   dout
);
    logic [DWIDTH-1:0] res_arr [NUM_LANE];

    generate
        for (genvar gi = 0; gi < NUM_LANE; gi++) begin : g_lane
            logic [DWIDTH-1:0] lane_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    lane_reg <= '0;
                end else if (load) begin
                    lane_reg <= din[gi];
                end
            end
            assign res_arr[gi] = lane_reg;
        end
    endgenerate

    assign dout = res_arr[sel];
endmodule

// File: rtl/fc_layer_sequencer.sv
// Sequences one fully-connected layer in groups of four output nodes:
// launch the data mover, capture its four results, burst them into the result BRAM.
module fc_layer_sequencer
    import fc_pkg::*;
#(
    parameter int CNT_BIT = 31,
    parameter int GRP_BIT = 10,
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 12
) (
    input logic clk,
    input logic reset,
    fc_layer_sequencer_if.master bus
);
    state_t              state_reg, state_next;
    logic [CNT_BIT-1:0]  num_cnt_reg;
    logic [GRP_BIT-1:0]  num_grp_reg;
    logic [AWIDTH-1:0]   res_base_reg;
    logic [GRP_BIT-1:0]  grp_reg;
    logic [LANE_BIT-1:0] lane_reg;
    logic [AWIDTH-1:0]   wgt_base_reg;

    logic                accept;
    logic                load_res;
    logic                wr_active;
    logic                grp_advance;
    logic                lane_last;
    logic                grp_last;
    logic [DWIDTH-1:0]   result_arr [NUM_LANE];
    logic [DWIDTH-1:0]   buf_dout;

    assign lane_last = (lane_reg == LANE_BIT'(NUM_LANE - 1));
    assign grp_last  = (grp_reg == (num_grp_reg - GRP_BIT'(1)));

    assign result_arr[0] = bus.i_result_0;
    assign result_arr[1] = bus.i_result_1;
    assign result_arr[2] = bus.i_result_2;
    assign result_arr[3] = bus.i_result_3;

    fc_result_buffer #(.DWIDTH(DWIDTH)) u_result_buffer (
        .clk   (clk),
        .reset (reset),
        .load  (load_res),
        .din   (result_arr),
        .sel   (lane_reg),
        .dout  (buf_dout)
    );

    always_comb begin
        state_next   = state_reg;
        accept       = 1'b0;
        load_res     = 1'b0;
        wr_active    = 1'b0;
        grp_advance  = 1'b0;
        bus.o_dm_run = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bus.i_run) begin
                    accept = 1'b1;
                    // Empty layers skip straight to completion.
                    if (bus.i_num_grp == '0 || bus.i_num_cnt == '0) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                if (bus.i_dm_idle) begin
                    bus.o_dm_run = 1'b1;
                    state_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.i_dm_done) begin
                    load_res   = 1'b1;
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                wr_active = 1'b1;
                if (lane_last) begin
                    if (grp_last) begin
                        state_next = S_DONE;
                    end else begin
                        grp_advance = 1'b1;
                        state_next  = S_LAUNCH;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            num_cnt_reg  <= '0;
            num_grp_reg  <= '0;
            res_base_reg <= '0;
            grp_reg      <= '0;
            lane_reg     <= '0;
            wgt_base_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                num_cnt_reg  <= bus.i_num_cnt;
                num_grp_reg  <= bus.i_num_grp;
                res_base_reg <= bus.i_res_base;
                grp_reg      <= '0;
                wgt_base_reg <= '0;
            end
            if (load_res) begin
                lane_reg <= '0;
            end else if (wr_active) begin
                lane_reg <= lane_reg + LANE_BIT'(1);
            end
            // Weight base steps by the per-group word count, wrapping in the BRAM address space.
            if (grp_advance) begin
                grp_reg      <= grp_reg + GRP_BIT'(1);
                wgt_base_reg <= wgt_base_reg + AWIDTH'(num_cnt_reg);
            end
        end
    end

    assign bus.o_idle       = (state_reg == S_IDLE);
    assign bus.o_busy       = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign bus.o_done       = (state_reg == S_DONE);
    assign bus.o_dm_num_cnt = num_cnt_reg;
    assign bus.o_wgt_base   = wgt_base_reg;
    assign bus.o_wr_ce      = wr_active;
    assign bus.o_wr_we      = wr_active;
    assign bus.o_wr_addr    = wr_active
                            ? (res_base_reg + (AWIDTH'(grp_reg) << 2) + AWIDTH'(lane_reg))
                            : '0;
    assign bus.o_wr_data    = wr_active ? buf_dout : '0;
endmodule
